normalize_pipe: RTL and testbench
=================================

NORMALIZE_PIPE -- requirements
Module: normalize_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data width, power of two, 8..128.
REQ-002 SHALL have parameter STAGES, default 2: register stages, 1..log2(WIDTH).
REQ-003 SHALL have parameter TAG_W, default 4: width of the sideband tag carried with each operand.
REQ-004 SHALL have port clock, input, 1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_n, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port flush, input, 1: synchronous discard of all in-flight operands.
REQ-007 SHALL have port in_valid, input, 1: operand offered.
REQ-008 SHALL have port in_ready, output, 1: operand accepted when in_valid & in_ready at a clock edge.
REQ-009 SHALL have port in_data, input, WIDTH: value to normalise.
REQ-010 SHALL have port in_tag, input, TAG_W: sideband, passed through unchanged.
REQ-011 SHALL have port out_valid, output, 1: result available.
REQ-012 SHALL have port out_ready, input, 1: result consumed when out_valid & out_ready at a clock edge.
REQ-013 SHALL have port out_data, output, WIDTH: normalised value; MSB is 1 unless the operand was zero.
REQ-014 SHALL have port out_distance, output, log2(WIDTH): left-shift amount applied.
REQ-015 SHALL have port out_zero, output, 1: operand was zero.
REQ-016 SHALL have port out_tag, output, TAG_W: tag of the result.

Function
REQ-017 SHALL normalise using L = log2(WIDTH) shift levels, MSB-first; level k (k = L-1 down to 0): if the top 2^k bits of the partial value are zero, shift left by 2^k and set distance bit k.
REQ-018 SHALL assign levels to stages contiguously: stage s holds levels floor(s*L/STAGES) .. floor((s+1)*L/STAGES)-1, counted from the MSB level.
REQ-019 SHALL give zero input out_distance = WIDTH-1, out_data = 0 and out_zero = 1; out_zero SHALL be 0 for any non-zero input.
REQ-020 SHALL have latency of exactly STAGES cycles from acceptance to out_valid when not stalled; throughput SHALL be one operand per cycle.
REQ-021 SHALL give each stage s a valid bit v[s]; stage s loads when ~v[s] | advance[s+1], where advance of the last stage = out_ready.
REQ-022 SHALL collapse bubbles: an empty stage accepts from upstream even while downstream is stalled.
REQ-023 SHALL drive in_ready = ~flush & (~v[0] | advance[1]); the combinational ready path from out_ready to in_ready is permitted.
REQ-024 SHALL hold out_data, out_distance, out_zero and out_tag stable while out_valid & ~out_ready.
REQ-025 SHALL preserve operand order; no operand is dropped or duplicated except by flush or reset.
REQ-026 SHALL, on flush, clear all v[s] at the next edge; flush SHALL win over a simultaneous in_valid (not accepted) and over a simultaneous output handshake (the result counts as consumed only if out_ready was high).
REQ-027 SHALL hold data registers when their stage does not load; data SHALL NOT be reset.

Reset
REQ-028 SHALL, while reset_n is low, force all v[s] = 0 and therefore out_valid = 0 and in_ready = 0, independent of clock.
REQ-029 SHALL leave out_data, out_distance, out_zero and out_tag undefined in reset and until the first out_valid.
REQ-030 SHALL make in_ready = 1 from the first edge after reset_n deasserts; reset mid-operation discards all in-flight operands.

Structure
REQ-031 SHALL place log2 helper, level-to-stage mapping function and distance width constant in shared package normalize_pkg.
REQ-032 SHALL use one combinational sub-module normalize_level (parameters WIDTH and K: one level's test, shift and distance bit), instantiated L times.
REQ-033 SHALL contain no arithmetic beyond shifts and zero tests; no latches.

Verification
REQ-034 SHALL cover WIDTH=32, STAGES=2, in_data=0x00012345 -> out_data 0x91A28000, out_distance 15, out_zero 0, out_valid exactly 2 cycles after acceptance.
REQ-035 SHALL cover in_data=0x00000001 -> 0x80000000/31/0; in_data=0 -> 0x00000000/31/1; in_data=0x80000000 -> 0x80000000/0/0.
REQ-036 SHALL cover 6 back-to-back operands with out_ready low for cycles 2-5 -> in_ready low once 2 held, all 6 results in order with tags 0..5, none lost.
REQ-037 SHALL cover flush asserted with 2 in flight and in_valid high -> next cycle out_valid 0, flushed operand not accepted, following operand emerges normally.
REQ-038 SHALL cover reset_n pulsed low mid-stream -> out_valid 0 immediately, in_ready 1 one edge after release, no stale result emitted.
REQ-039 SHALL cover a random sweep for WIDTH in {8,64,128} and STAGES in {1,L} against a reference leading-zero count, with random in/out stalls.

Source files
------------

// File: rtl/normalize_pkg.sv
// normalize_pkg: shared width helpers and level-to-stage mapping for normalize_pipe
package normalize_pkg;
  localparam int DEF_WIDTH = 32;
  function automatic int log2(input int n);
    int r = 0;
    for (int v = n; v > 1; v = v >> 1) r++;
    return r;
  endfunction
  function automatic int dist_w(input int width);
    return log2(width);
  endfunction
  // first level (counted from the MSB level) owned by stage s
  function automatic int stage_lo(input int s, input int l, input int stages);
    return (s * l) / stages;
  endfunction
  function automatic int stage_of(input int i, input int l, input int stages);
    int r = 0;
    for (int s = 0; s < stages; s++) if (i >= stage_lo(s, l, stages)) r = s;
    return r;
  endfunction
endpackage

// File: rtl/normalize_level.sv
// normalize_level: one shift level; shifts left by 2^K when the top 2^K bits are zero
module normalize_level #(
  parameter int WIDTH = 32,
  parameter int K = 0
) (
  input  logic [WIDTH-1:0] x_i,
  output logic [WIDTH-1:0] y_o,
  output logic             d_o
);
  assign d_o = ~|x_i[WIDTH-1 -: (1 << K)];
  assign y_o = d_o ? x_i << (1 << K) : x_i;
endmodule

// File: rtl/normalize_pipe.sv
// normalize_pipe: pipelined leading-zero normaliser with valid/ready flow control and flush
module normalize_pipe
  import normalize_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int STAGES = 2,
  parameter int TAG_W = 4
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_data,
  input  logic [TAG_W-1:0]          in_tag,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [dist_w(WIDTH)-1:0]  out_distance,
  output logic                      out_zero,
  output logic [TAG_W-1:0]          out_tag
);
  localparam int L = dist_w(WIDTH);
  logic [STAGES-1:0] v_q, v_d;
  logic [STAGES:0]   ld;
  logic              en_q;
  logic [WIDTH-1:0]  data_q [STAGES];
  logic [L-1:0]      dist_q [STAGES];
  logic [TAG_W-1:0]  tag_q  [STAGES];
  logic [WIDTH-1:0]  stg_y  [STAGES];
  logic [L-1:0]      stg_d  [STAGES];

  for (genvar i = 0; i < L; i++) begin : g_lvl
    localparam int S = stage_of(i, L, STAGES);
    localparam int K = L - 1 - i;
    logic [WIDTH-1:0] x, y;
    logic [L-1:0]     di, dn;
    logic             z;
    if (i == stage_lo(S, L, STAGES)) begin : g_head
      if (S == 0) begin : g_in
        assign x  = in_data;
        assign di = '0;
      end else begin : g_reg
        assign x  = data_q[S-1];
        assign di = dist_q[S-1];
      end
    end else begin : g_link
      assign x  = g_lvl[i-1].y;
      assign di = g_lvl[i-1].dn;
    end
    normalize_level #(.WIDTH(WIDTH), .K(K)) u_level (.x_i(x), .y_o(y), .d_o(z));
    assign dn = di | (L'(z) << K);
  end

  for (genvar s = 0; s < STAGES; s++) begin : g_stg
    localparam int H = stage_lo(s + 1, L, STAGES) - 1;
    assign stg_y[s] = g_lvl[H].y;
    assign stg_d[s] = g_lvl[H].dn;
  end

  // a stage loads when empty or when its content moves on downstream
  always_comb begin
    ld = '0;
    v_d = '0;
    ld[STAGES] = out_ready;
    for (int s = STAGES - 1; s >= 0; s--) ld[s] = ~v_q[s] | ld[s+1];
    v_d[0] = flush ? 1'b0 : ld[0] ? in_valid & en_q : v_q[0];
    for (int s = 1; s < STAGES; s++) v_d[s] = flush ? 1'b0 : ld[s] ? v_q[s-1] : v_q[s];
  end

  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      v_q  <= '0;
      en_q <= 1'b0;
    end else begin
      v_q  <= v_d;
      en_q <= 1'b1;
    end

  always_ff @(posedge clock) begin
    if (ld[0]) begin
      data_q[0] <= stg_y[0];
      dist_q[0] <= stg_d[0];
      tag_q[0]  <= in_tag;
    end
    for (int s = 1; s < STAGES; s++)
      if (ld[s]) begin
        data_q[s] <= stg_y[s];
        dist_q[s] <= stg_d[s];
        tag_q[s]  <= tag_q[s-1];
      end
  end

  assign in_ready     = en_q & ~flush & ld[0];
  assign out_valid    = v_q[STAGES-1];
  assign out_data     = data_q[STAGES-1];
  assign out_distance = dist_q[STAGES-1];
  assign out_tag      = tag_q[STAGES-1];
  assign out_zero     = ~data_q[STAGES-1][WIDTH-1];
endmodule

// File: tb/tb_normalize_pipe.sv
// tb_normalize_pipe: directed and randomised checks of normalize_pipe against a leading-zero model
module tb_normalize_pipe;
  localparam int N = 7;

  function automatic int w_of(input int g);
    return g == 0 ? 32 : g <= 2 ? 8 : g <= 4 ? 64 : 128;
  endfunction
  function automatic int s_of(input int g);
    return g == 0 ? 2 : g == 1 ? 1 : g == 2 ? 3 : g == 3 ? 1 : g == 4 ? 6 : g == 5 ? 1 : 7;
  endfunction
  function automatic logic [127:0] mask(input int w);
    return w >= 128 ? '1 : (128'(1) << w) - 128'(1);
  endfunction
  // leading-zero reference: count zeros from the top, zero operand gives w-1
  function automatic void model(input logic [127:0] x, input int w, output logic [127:0] y, output int d);
    d = 0;
    while (d < w - 1 && !x[w-1-d]) d++;
    y = (x << d) & mask(w);
  endfunction

  logic clock = 1'b0;
  logic reset_n = 1'b1;
  logic [N-1:0] flush, in_valid, in_ready, out_valid, out_ready, out_zero;
  logic [127:0] in_data [N];
  logic [127:0] out_data [N];
  logic [6:0]   out_dist [N];
  logic [3:0]   in_tag [N];
  logic [3:0]   out_tag [N];

  int checks = 0;
  int errors = 0;
  logic [131:0] sq [N][$];
  int           pops [N] = '{default: 0};
  logic         hold [N] = '{default: 1'b0};
  logic [127:0] p_data [N];
  logic [6:0]   p_dist [N];
  logic         p_zero [N];
  logic [3:0]   p_tag [N];

  always #5 clock = ~clock;

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int W = w_of(g);
    localparam int L = $clog2(W);
    logic [W-1:0] od;
    logic [L-1:0] dd;
    normalize_pipe #(.WIDTH(W), .STAGES(s_of(g)), .TAG_W(4)) u_dut (
      .clock(clock), .reset_n(reset_n), .flush(flush[g]),
      .in_valid(in_valid[g]), .in_ready(in_ready[g]),
      .in_data(in_data[g][W-1:0]), .in_tag(in_tag[g]),
      .out_valid(out_valid[g]), .out_ready(out_ready[g]),
      .out_data(od), .out_distance(dd), .out_zero(out_zero[g]), .out_tag(out_tag[g]));
    assign out_data[g] = 128'(od);
    assign out_dist[g] = 7'(dd);
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic busy();
    logic b = 1'b0;
    for (int g = 0; g < N; g++) b |= (sq[g].size() != 0) | out_valid[g];
    return b;
  endfunction

  always @(negedge clock) begin
    logic [131:0] e;
    logic [127:0] ey;
    int ed, w;
    for (int g = 0; g < N; g++) begin
      w = w_of(g);
      if (!reset_n) begin
        sq[g].delete();
        hold[g] = 1'b0;
        chk($sformatf("reset_valid[%0d]", g), 128'(out_valid[g]), 128'(0));
        chk($sformatf("reset_ready[%0d]", g), 128'(in_ready[g]), 128'(0));
      end else begin
        if (hold[g]) begin
          chk($sformatf("hold_valid[%0d]", g), 128'(out_valid[g]), 128'(1));
          chk($sformatf("hold_data[%0d]", g), out_data[g], p_data[g]);
          chk($sformatf("hold_dist[%0d]", g), 128'(out_dist[g]), 128'(p_dist[g]));
          chk($sformatf("hold_zero_tag[%0d]", g), 128'({out_zero[g], out_tag[g]}), 128'({p_zero[g], p_tag[g]}));
        end
        if (out_valid[g]) begin
          chk($sformatf("pending_at_output[%0d]", g), 128'(sq[g].size() > 0), 128'(1));
          if (out_ready[g] && sq[g].size() > 0) begin
            e = sq[g].pop_front();
            model(e[127:0], w, ey, ed);
            chk($sformatf("out_data[%0d]", g), out_data[g], ey);
            chk($sformatf("out_distance[%0d]", g), 128'(out_dist[g]), 128'(ed));
            chk($sformatf("out_zero[%0d]", g), 128'(out_zero[g]), 128'(e[127:0] == '0));
            chk($sformatf("out_tag[%0d]", g), 128'(out_tag[g]), 128'(e[131:128]));
            pops[g]++;
          end
        end
        hold[g] = out_valid[g] & ~out_ready[g] & ~flush[g];
        p_data[g] = out_data[g];
        p_dist[g] = out_dist[g];
        p_zero[g] = out_zero[g];
        p_tag[g] = out_tag[g];
        if (in_valid[g] && in_ready[g]) sq[g].push_back({in_tag[g], in_data[g] & mask(w)});
        if (flush[g]) sq[g].delete();
      end
    end
  end

  task automatic run1(input logic [31:0] d, input logic [3:0] t, input logic [31:0] ey, input int ed, input logic ez);
    int n;
    out_ready[0] = 1'b1;
    in_valid[0] = 1'b1;
    in_data[0] = 128'(d);
    in_tag[0] = t;
    #1;
    chk($sformatf("single_in_ready_%h", d), 128'(in_ready[0]), 128'(1));
    tick();
    in_valid[0] = 1'b0;
    n = 1;
    while (!out_valid[0] && n < 10) begin
      tick();
      n++;
    end
    chk($sformatf("latency_%h", d), 128'(n), 128'(2));
    chk($sformatf("lit_data_%h", d), out_data[0], 128'(ey));
    chk($sformatf("lit_dist_%h", d), 128'(out_dist[0]), 128'(ed));
    chk($sformatf("lit_zero_%h", d), 128'(out_zero[0]), 128'(ez));
    chk($sformatf("lit_tag_%h", d), 128'(out_tag[0]), 128'(t));
    tick();
  endtask

  task automatic feed0(input logic [31:0] d, input logic [3:0] t);
    in_valid[0] = 1'b1;
    in_data[0] = 128'(d);
    in_tag[0] = t;
    tick();
    in_valid[0] = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] b2b [6];
    logic [127:0] ey;
    int ed, acc, p0;
    b2b = '{32'h0000_0001, 32'h00F0_0000, 32'h0000_0000, 32'h7FFF_FFFF, 32'h0000_0300, 32'hDEAD_BEEF};
    flush = '0;
    in_valid = '0;
    out_ready = '0;
    for (int g = 0; g < N; g++) begin
      in_data[g] = '0;
      in_tag[g] = '0;
    end
    model(128'h0001_2345, 32, ey, ed);
    chk("model_data_12345", ey, 128'h91A2_8000);
    chk("model_dist_12345", 128'(ed), 128'(15));
    model(128'h0, 32, ey, ed);
    chk("model_zero", {ey[95:0], 32'(ed)}, 128'(31));
    #1 reset_n = 1'b0;
    #1;
    chk("reset_in_ready", 128'(in_ready), 128'(0));
    chk("reset_out_valid", 128'(out_valid), 128'(0));
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    chk("release_in_ready", 128'(in_ready), 128'({N{1'b1}}));

    run1(32'h0001_2345, 4'd1, 32'h91A2_8000, 15, 1'b0);
    run1(32'h0000_0001, 4'd2, 32'h8000_0000, 31, 1'b0);
    run1(32'h0000_0000, 4'd3, 32'h0000_0000, 31, 1'b1);
    run1(32'h8000_0000, 4'd4, 32'h8000_0000, 0, 1'b0);

    acc = 0;
    p0 = pops[0];
    for (int c = 0; c < 40 && acc < 6; c++) begin
      out_ready[0] = !(c >= 2 && c <= 5);
      in_valid[0] = 1'b1;
      in_data[0] = 128'(b2b[acc]);
      in_tag[0] = 4'(acc);
      #1;
      if (c == 1) chk("b2b_ready_c1", 128'(in_ready[0]), 128'(1));
      if (c == 2 || c == 5) chk($sformatf("b2b_ready_c%0d", c), 128'(in_ready[0]), 128'(0));
      if (in_ready[0]) acc++;
      tick();
    end
    in_valid[0] = 1'b0;
    out_ready[0] = 1'b1;
    for (int i = 0; i < 20 && busy(); i++) tick();
    chk("b2b_accepted", 128'(acc), 128'(6));
    chk("b2b_results", 128'(pops[0] - p0), 128'(6));

    p0 = pops[0];
    feed0(32'h0000_0100, 4'd6);
    feed0(32'h0040_0000, 4'd7);
    in_valid[0] = 1'b1;
    in_data[0] = 128'h3;
    in_tag[0] = 4'd8;
    flush[0] = 1'b1;
    #1;
    chk("flush_in_ready", 128'(in_ready[0]), 128'(0));
    chk("flush_head_valid", 128'(out_valid[0]), 128'(1));
    tick();
    flush[0] = 1'b0;
    chk("flush_out_valid", 128'(out_valid[0]), 128'(0));
    feed0(32'h0000_0020, 4'd9);
    for (int i = 0; i < 20 && busy(); i++) tick();
    chk("flush_results", 128'(pops[0] - p0), 128'(2));

    p0 = pops[0];
    out_ready[0] = 1'b0;
    feed0(32'h0000_1000, 4'd10);
    feed0(32'h0200_0000, 4'd11);
    tick();
    chk("pre_reset_valid", 128'(out_valid[0]), 128'(1));
    reset_n = 1'b0;
    #1;
    chk("reset_async_valid", 128'(out_valid[0]), 128'(0));
    chk("reset_async_ready", 128'(in_ready[0]), 128'(0));
    @(negedge clock);
    #1;
    reset_n = 1'b1;
    out_ready[0] = 1'b1;
    tick();
    chk("post_reset_ready", 128'(in_ready[0]), 128'(1));
    for (int i = 0; i < 4; i++) begin
      chk("post_reset_no_stale", 128'(out_valid[0]), 128'(0));
      tick();
    end
    chk("reset_results", 128'(pops[0] - p0), 128'(0));

    for (int c = 0; c < 2500; c++) begin
      for (int g = 0; g < N; g++) begin
        logic [127:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        r = (r & mask(w_of(g))) >> $urandom_range(0, w_of(g) - 1);
        in_valid[g] = ($urandom % 4) != 0;
        out_ready[g] = ($urandom % 3) != 0;
        in_data[g] = ($urandom % 16 == 0) ? '0 : r;
        in_tag[g] = 4'($urandom);
      end
      tick();
    end
    for (int g = 0; g < N; g++) begin
      in_valid[g] = 1'b0;
      out_ready[g] = 1'b1;
    end
    for (int i = 0; i < 50 && busy(); i++) tick();
    for (int g = 0; g < N; g++) begin
      chk($sformatf("drain_empty[%0d]", g), 128'(sq[g].size()), 128'(0));
      chk($sformatf("sweep_activity[%0d]", g), 128'(pops[g] > 100), 128'(1));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
